// File: rtl/control_sequencer_if.sv
// Control sequencer bus interface.
// Bundles the instruction/status/memory-handshake inputs and every
// register-bank and datapath control output of the sequencer.
//   master : sequencer side (drives controls, receives IR/flags/mem_ready)
//   slave  : datapath side (drives IR/flags/mem_ready, receives controls)
interface control_sequencer_if;
  logic [15:0] instruction;
  logic        status_z;
  logic        status_n;
  logic        status_c;
  logic        status_ov;
  logic        mem_ready;

  logic [3:0]  select;
  logic [3:0]  load;
  logic        loadenable;
  logic        hi_loadenable;
  logic        inc_pc;
  logic        statenable;
  logic        enable;

  logic [3:0]  alu_op;
  logic [1:0]  alu_a;
  logic [1:0]  alu_b;
  logic        mem_read;
  logic        mem_write;
  logic        halted;
  logic        fault;

  modport master (
    input  instruction, status_z, status_n, status_c, status_ov, mem_ready,
    output select, load, loadenable, hi_loadenable, inc_pc, statenable, enable,
    output alu_op, alu_a, alu_b, mem_read, mem_write, halted, fault
  );

  modport slave (
    output instruction, status_z, status_n, status_c, status_ov, mem_ready,
    input  select, load, loadenable, hi_loadenable, inc_pc, statenable, enable,
    input  alu_op, alu_a, alu_b, mem_read, mem_write, halted, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Control sequencer: microcoded-style FSM that fetches an instruction over
// the internal bus, decodes it and issues register-bank / ALU / memory
// controls for one instruction at a time.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset
//   bus    - control_sequencer_if.master: instruction, status flags,
//            mem_ready in; select/load/enables, alu_op/alu_a/alu_b,
//            mem_read/mem_write, halted, fault out
//
// Optional feature: define MEM_TIMEOUT_EN to add a 4-bit memory wait
// counter; 15 consecutive wait cycles send the sequencer to HALT with a
// sticky fault. Without it waits are unbounded and fault is tied 0.
//
// Control outputs are decoded from the state register (and mem_ready in the
// two wait states, so a ready access completes in the same cycle).
module control_sequencer (
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.master bus
);

  localparam int unsigned BUS_W = 4;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned IDX_W = 2;

  // Bus source/destination codes
  localparam logic [BUS_W-1:0] BUS_D0  = BUS_W'(1);
  localparam logic [BUS_W-1:0] BUS_A0  = BUS_W'(5);
  localparam logic [BUS_W-1:0] BUS_PC  = BUS_W'(11);
  localparam logic [BUS_W-1:0] BUS_IR  = BUS_W'(14);
  localparam logic [BUS_W-1:0] BUS_ALU = BUS_W'(14);
  localparam logic [BUS_W-1:0] BUS_MEM = BUS_W'(15);

  // Opcodes
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MOV  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BZ   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BN   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(15);

  // ALU function that passes the 12-bit immediate through
  localparam logic [OP_W-1:0] ALU_PASS = OP_W'(9);

  typedef enum logic [2:0] {
    FETCH_A,
    FETCH_M,
    DECODE,
    EXEC,
    MEM_A,
    MEM_W,
    HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  // Low for the cycle after each reset edge so the first FETCH_A outputs
  // show up only once reset has been released.
  logic started;

  logic [OP_W-1:0]  op;
  logic [IDX_W-1:0] dst;
  logic [IDX_W-1:0] src;
  logic [BUS_W-1:0] dst_reg;
  logic [BUS_W-1:0] src_reg;
  logic             alu_class;
  logic             jump_taken;
  logic             ready;
  logic             timeout_c;

  logic [BUS_W-1:0] select_c;
  logic [BUS_W-1:0] load_c;
  logic             loadenable_c;
  logic             hi_loadenable_c;
  logic             inc_pc_c;
  logic             statenable_c;
  logic             enable_c;
  logic [OP_W-1:0]  alu_op_c;
  logic [IDX_W-1:0] alu_a_c;
  logic [IDX_W-1:0] alu_b_c;
  logic             mem_read_c;
  logic             mem_write_c;
  logic             halted_c;

  // Instruction field decode
  assign op       = bus.instruction[15:12];
  assign dst      = bus.instruction[11:10];
  assign src      = bus.instruction[9:8];
  assign dst_reg  = BUS_D0 + BUS_W'(dst);
  assign src_reg  = BUS_D0 + BUS_W'(src);

  assign alu_class  = (op >= OP_ADD) && (op <= OP_MUL);
  assign jump_taken = (op == OP_JMP) ||
                      ((op == OP_BZ) && bus.status_z) ||
                      ((op == OP_BN) && bus.status_n);

  // A ready seen while reset is high must not complete an access.
  assign ready = bus.mem_ready & ~reset;

  // Immediate bits feed the ALU directly; carry/overflow flags have no
  // conditional branch that reads them.
  logic unused_inputs;
  assign unused_inputs = ^{bus.instruction[7:0], bus.status_c, bus.status_ov};

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W     = 4;
  localparam int unsigned WAIT_LIMIT = 15;

  logic [WAIT_W-1:0] wait_cnt;
  logic              fault_q;
  logic              in_wait;

  assign in_wait   = started && ((state == FETCH_M) || (state == MEM_W));
  // Fires on the 15th consecutive cycle without mem_ready
  assign timeout_c = in_wait && !ready && (wait_cnt == WAIT_W'(WAIT_LIMIT - 1));

  // Wait counter cleared whenever a wait state is (re)entered; sticky fault
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (!in_wait) begin
        wait_cnt <= '0;
      end else if (!ready) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (timeout_c) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign bus.fault = fault_q;
`else
  assign timeout_c = 1'b0;
  assign bus.fault = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH_A;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (started) begin
        state <= state_nxt;
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt       = state;
    select_c        = '0;
    load_c          = '0;
    loadenable_c    = 1'b0;
    hi_loadenable_c = 1'b0;
    inc_pc_c        = 1'b0;
    statenable_c    = 1'b0;
    enable_c        = 1'b0;
    alu_op_c        = '0;
    alu_a_c         = '0;
    alu_b_c         = '0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    halted_c        = 1'b0;

    if (started) begin
      if (state != HALT) begin
        enable_c = 1'b1;
        alu_a_c  = dst;
        alu_b_c  = src;
      end

      case (state)
        FETCH_A: begin
          select_c     = BUS_PC;
          load_c       = BUS_A0;
          loadenable_c = 1'b1;
          state_nxt    = FETCH_M;
        end

        FETCH_M: begin
          mem_read_c = 1'b1;
          if (ready) begin
            select_c     = BUS_MEM;
            load_c       = BUS_IR;
            loadenable_c = 1'b1;
            inc_pc_c     = 1'b1;
            state_nxt    = DECODE;
          end else if (timeout_c) begin
            state_nxt = HALT;
          end
        end

        DECODE: begin
          if ((op == OP_LD) || (op == OP_ST)) begin
            state_nxt = MEM_A;
          end else if (op == OP_HALT) begin
            state_nxt = HALT;
          end else begin
            state_nxt = EXEC;
          end
        end

        // Single-cycle ops; NOP and untaken branches issue nothing
        EXEC: begin
          state_nxt = FETCH_A;
          if (alu_class) begin
            alu_op_c        = op;
            select_c        = BUS_ALU;
            load_c          = dst_reg;
            loadenable_c    = 1'b1;
            statenable_c    = 1'b1;
            hi_loadenable_c = (op == OP_MUL);
          end else if (op == OP_MOV) begin
            select_c     = src_reg;
            load_c       = dst_reg;
            loadenable_c = 1'b1;
          end else if (jump_taken) begin
            alu_op_c     = ALU_PASS;
            select_c     = BUS_ALU;
            load_c       = BUS_PC;
            loadenable_c = 1'b1;
          end
        end

        MEM_A: begin
          select_c     = src_reg;
          load_c       = BUS_A0;
          loadenable_c = 1'b1;
          state_nxt    = MEM_W;
        end

        MEM_W: begin
          if (op == OP_LD) begin
            mem_read_c = 1'b1;
            if (ready) begin
              select_c     = BUS_MEM;
              load_c       = dst_reg;
              loadenable_c = 1'b1;
            end
          end else begin
            select_c    = dst_reg;
            mem_write_c = 1'b1;
          end
          if (ready) begin
            state_nxt = FETCH_A;
          end else if (timeout_c) begin
            state_nxt = HALT;
          end
        end

        HALT: begin
          halted_c = 1'b1;
        end

        default: begin
          state_nxt = FETCH_A;
        end
      endcase
    end
  end

  assign bus.select        = select_c;
  assign bus.load          = load_c;
  assign bus.loadenable    = loadenable_c;
  assign bus.hi_loadenable = hi_loadenable_c;
  assign bus.inc_pc        = inc_pc_c;
  assign bus.statenable    = statenable_c;
  assign bus.enable        = enable_c;
  assign bus.alu_op        = alu_op_c;
  assign bus.alu_a         = alu_a_c;
  assign bus.alu_b         = alu_b_c;
  assign bus.mem_read      = mem_read_c;
  assign bus.mem_write     = mem_write_c;
  assign bus.halted        = halted_c;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL have inputs: instruction  in  16  current IR contents; status_z/status_n/status_c/status_ov  in  1 each  latched flags; mem_ready  in  1  memory access complete.
REQ-003 SHALL have register-bank control outputs: select  out  4  bus source; load  out  4  bus destination; loadenable, hi_loadenable, inc_pc, statenable, enable  out  1 each.
REQ-004 SHALL have datapath outputs: alu_op  out  4  ALU function; alu_a  out  2  d-register index A; alu_b  out  2  d-register index B; mem_read, mem_write  out  1 each; halted  out  1; fault  out  1.
REQ-005 SHALL use the bus codes 0=zero, 1..4=d0..d3, 5=a0, 8=dr, 9=sr, 10=ba, 11=pc, 12=hi, 13=lo, 14=alu, 15=mem for select, and 14=ir for load.

Function
REQ-006 SHALL implement the states FETCH_A, FETCH_M, DECODE, EXEC, MEM_A, MEM_W, HALT.
REQ-007 FETCH_A SHALL drive select=11 and load=5 with loadenable=1, then move to FETCH_M.
REQ-008 FETCH_M SHALL hold mem_read=1 until mem_ready is high. In the cycle mem_ready is high it SHALL drive select=15, load=14, loadenable=1 and inc_pc=1 (one-cycle pulse), then move to DECODE.
REQ-009 DECODE SHALL decode the instruction fields: op=instruction[15:12], dst=[11:10], src=[9:8]. alu_a SHALL equal dst and alu_b SHALL equal src.
REQ-010 Opcodes and their effects:
- 0 NOP.
- 1 ADD, 2 SUB, 3 AND, 4 OR: EXEC with alu_op=op, select=14, load=1+dst, loadenable=1, statenable=1.
- 5 MUL: as ADD, plus hi_loadenable=1.
- 6 MOV: select=1+src, load=1+dst.
- 7 LD, 8 ST: go to MEM_A.
- 9 JMP: alu_op=9 (pass immediate12bit), select=14, load=11.
- A BZ / B BN: as JMP only if status_z / status_n is 1, otherwise no load.
- F HALT: go to HALT.
- C, D, E: treated as NOP.
REQ-011 NOP, MOV, JMP and taken or untaken branches SHALL complete in EXEC with no further state, then return to FETCH_A.
REQ-012 MEM_A SHALL drive select=1+src, load=5, loadenable=1, then move to MEM_W.
REQ-013 For LD, MEM_W SHALL hold mem_read=1 until mem_ready is high. In that cycle it SHALL drive select=15, load=1+dst, loadenable=1.
REQ-014 For ST, MEM_W SHALL drive select=1+dst and mem_write=1 until mem_ready is high. It SHALL not assert loadenable.
REQ-015 After MEM_W completes, the sequencer SHALL return to FETCH_A.
REQ-016 Latency with mem_ready tied high SHALL be:
- ALU, MOV, JMP, branch, NOP: 4 cycles per instruction.
- LD, ST: 5 cycles per instruction.
REQ-017 enable SHALL be 1 in every state except HALT. In HALT: enable=0, halted=1, and all other outputs 0.
REQ-018 HALT SHALL be sticky; only reset leaves it.
REQ-019 In any cycle not listed above, loadenable, statenable, hi_loadenable, inc_pc, mem_read and mem_write SHALL be 0, and select and load SHALL be 0.
REQ-020 inc_pc SHALL never be asserted on two consecutive cycles.
REQ-021 mem_ready sampled outside FETCH_M or MEM_W SHALL be ignored.

Reset
REQ-022 On reset high at a clock edge, the state SHALL become FETCH_A.
REQ-023 On that same edge, every output SHALL become 0, including halted and fault.
REQ-024 Reset asserted mid-access (FETCH_M or MEM_W) SHALL abort the access: mem_read and mem_write drop on the next edge and no load is issued.
REQ-025 The first FETCH_A outputs SHALL appear in the cycle after reset deasserts.

Configuration
REQ-026 Macro MEM_TIMEOUT_EN, when defined, SHALL add a 4-bit wait counter that is cleared on entry to FETCH_M or MEM_W.
REQ-027 With MEM_TIMEOUT_EN defined, if mem_ready stays low for 15 consecutive wait cycles, the sequencer SHALL go to HALT and set fault=1 (sticky until reset).
REQ-028 With MEM_TIMEOUT_EN undefined, waits SHALL be unbounded and fault SHALL be constant 0.

Verification
REQ-029 ADD: reset, then instruction=0x1600 with mem_ready=1 -> FETCH_A select=11/load=5; FETCH_M select=15/load=14/inc_pc=1; EXEC alu_op=1, select=14, load=2, statenable=1; next instruction fetch at cycle 5.
REQ-030 LD with stalls: instruction=0x7400 (dst=1, src=0), mem_ready low for 3 cycles in MEM_W -> MEM_A select=1/load=5; mem_read held 4 cycles; on ready select=15, load=2, loadenable=1.
REQ-031 Branches: BZ=0xA005 with status_z=1 -> select=14, load=11, alu_op=9. With status_z=0 -> loadenable=0 in EXEC.
REQ-032 HALT: instruction=0xF000 -> halted=1 and enable=0 from the cycle after DECODE. Toggling mem_ready SHALL not change any output. Reset SHALL return the sequencer to FETCH_A.
REQ-033 Reset mid-fetch: assert reset during FETCH_M with mem_ready=0 -> mem_read=0 and loadenable=0 after the edge. No inc_pc pulse SHALL be observed.
REQ-034 Timeout (MEM_TIMEOUT_EN defined): hold mem_ready=0 in FETCH_M -> after the 15th wait cycle, fault=1 and halted=1. The same stimulus without the macro SHALL keep mem_read=1 indefinitely.
